// File: rtl/sram_arbiter.sv
// Arbitrates ibus/dbus sram masters onto one memory port with a timeout watchdog.
// Define SRAM_ARBITER_RR_EN for round-robin grant on ties; default is dbus priority.
module sram_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [31:0] i_addr,
  output logic        i_stall,
  output logic [31:0] i_data_r,
  output logic        i_err,
  input  logic        d_en,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_w,
  output logic        d_stall,
  output logic [31:0] d_data_r,
  output logic        d_err,
  output logic        mem_req,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             gnt_d;
  logic             gnt_i;
  logic             to_hit;

`ifdef SRAM_ARBITER_RR_EN
  logic last_owner;

  // On a tie, serve whoever was not granted last.
  always_comb begin
    gnt_d = d_en && (!i_en || last_owner == OWN_I);
    gnt_i = i_en && !gnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_owner <= OWN_I;
    end else if (state == IDLE) begin
      if (gnt_d)
        last_owner <= OWN_D;
      else if (gnt_i)
        last_owner <= OWN_I;
    end
  end
`else
  always_comb begin
    gnt_d = d_en;
    gnt_i = i_en && !d_en;
  end
`endif

  assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign mem_req = (state == BUSY);

  // Stall drops only in the owner's RESP cycle.
  assign i_stall = i_en && !(state == RESP && owner == OWN_I);
  assign d_stall = d_en && !(state == RESP && owner == OWN_D);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      cnt       <= '0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_data_r  <= '0;
      d_data_r  <= '0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      i_err <= 1'b0;
      d_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt_d) begin
            owner     <= OWN_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_data_w;
            state     <= BUSY;
          end else if (gnt_i) begin
            owner     <= OWN_I;
            mem_we    <= '0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (owner == OWN_D)
              d_data_r <= mem_rdata;
            else
              i_data_r <= mem_rdata;
            state <= RESP;
          end else if (to_hit) begin
            if (owner == OWN_D)
              d_err <= 1'b1;
            else
              i_err <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Cycle-by-cycle vector bench for sram_arbiter (TIMEOUT=4).
// Inputs applied at negedge, outputs sampled 1ns later.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [31:0] i_addr;
  logic        i_stall;
  logic [31:0] i_data_r;
  logic        i_err;
  logic        d_en;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_data_w;
  logic        d_stall;
  logic [31:0] d_data_r;
  logic        d_err;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_en(i_en), .i_addr(i_addr), .i_stall(i_stall),
    .i_data_r(i_data_r), .i_err(i_err),
    .d_en(d_en), .d_we(d_we), .d_addr(d_addr), .d_data_w(d_data_w),
    .d_stall(d_stall), .d_data_r(d_data_r), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        rst;
    logic        ien;
    logic [31:0] ia;
    logic        den;
    logic [3:0]  dwe;
    logic [31:0] da;
    logic [31:0] dw;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_is;
    logic        e_ds;
    logic [31:0] e_idr;
    logic [31:0] e_ddr;
    logic        e_ie;
    logic        e_de;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic ie, logic [31:0] ia,
    logic de, logic [3:0] dwe, logic [31:0] da, logic [31:0] dw,
    logic ak, logic [31:0] rd,
    logic req, logic [3:0] we, logic [31:0] ad, logic [31:0] wd,
    logic is_, logic ds, logic [31:0] idr, logic [31:0] ddr,
    logic ierr, logic derr);
    vec_t v;
    v.rst = r; v.ien = ie; v.ia = ia;
    v.den = de; v.dwe = dwe; v.da = da; v.dw = dw;
    v.ack = ak; v.rd = rd;
    v.e_req = req; v.e_we = we; v.e_addr = ad; v.e_wd = wd;
    v.e_is = is_; v.e_ds = ds; v.e_idr = idr; v.e_ddr = ddr;
    v.e_ie = ierr; v.e_de = derr;
    return v;
  endfunction

  task automatic chk(input int step, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
    end
  endtask

  initial begin
    // reset state
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0));
    // ibus read, immediate ack, then held en is not re-issued
    tbl.push_back(mk(1,1,32'hBFC00000,0,0,0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,32'hBFC00000,0,0,0,0,1,32'h3C080001, 1,0,32'hBFC00000,0, 1,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,32'hBFC00000,0,0,0,0,0,0, 0,0,32'hBFC00000,0, 0,0, 32'h3C080001,0, 0,0));
    tbl.push_back(mk(1,1,32'hBFC00000,0,0,0,0,0,0, 0,0,32'hBFC00000,0, 1,0, 32'h3C080001,0, 0,0));
    tbl.push_back(mk(1,1,32'hBFC00000,0,0,0,0,1,32'h11111111, 1,0,32'hBFC00000,0, 1,0, 32'h3C080001,0, 0,0));
    tbl.push_back(mk(1,1,32'hBFC00004,0,0,0,0,0,0, 0,0,32'hBFC00000,0, 0,0, 32'h11111111,0, 0,0));
    tbl.push_back(mk(1,1,32'hBFC00004,0,0,0,0,0,0, 0,0,32'hBFC00000,0, 1,0, 32'h11111111,0, 0,0));
    tbl.push_back(mk(1,1,32'hBFC00004,0,0,0,0,1,32'h22222222, 1,0,32'hBFC00004,0, 1,0, 32'h11111111,0, 0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,32'hBFC00004,0, 0,0, 32'h22222222,0, 0,0));
    // simultaneous requests: dbus write first, ibus stays stalled
    tbl.push_back(mk(1,1,32'h100,1,4'hF,32'h200,32'hDEADBEEF,0,0, 0,0,32'hBFC00004,0, 1,1, 32'h22222222,0, 0,0));
    tbl.push_back(mk(1,1,32'h100,1,4'hF,32'h200,32'hDEADBEEF,0,0, 1,4'hF,32'h200,32'hDEADBEEF, 1,1, 32'h22222222,0, 0,0));
    tbl.push_back(mk(1,1,32'h100,1,4'hF,32'h200,32'hDEADBEEF,1,32'hAAAA5555, 1,4'hF,32'h200,32'hDEADBEEF, 1,1, 32'h22222222,0, 0,0));
    tbl.push_back(mk(1,1,32'h100,1,4'hF,32'h200,32'hDEADBEEF,0,0, 0,4'hF,32'h200,32'hDEADBEEF, 1,0, 32'h22222222,32'hAAAA5555, 0,0));
    tbl.push_back(mk(1,1,32'h100,0,0,0,0,0,0, 0,4'hF,32'h200,32'hDEADBEEF, 1,0, 32'h22222222,32'hAAAA5555, 0,0));
    tbl.push_back(mk(1,1,32'h100,0,0,0,0,0,0, 1,0,32'h100,0, 1,0, 32'h22222222,32'hAAAA5555, 0,0));
    tbl.push_back(mk(1,1,32'h100,0,0,0,0,1,32'h0BADF00D, 1,0,32'h100,0, 1,0, 32'h22222222,32'hAAAA5555, 0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,32'h100,0, 0,0, 32'h0BADF00D,32'hAAAA5555, 0,0));
    // byte write passes strobes and address through
    tbl.push_back(mk(1,0,0,1,4'h3,32'h1002,32'h12345678,0,0, 0,0,32'h100,0, 0,1, 32'h0BADF00D,32'hAAAA5555, 0,0));
    tbl.push_back(mk(1,0,0,1,4'h3,32'h1002,32'h12345678,1,32'hCAFEF00D, 1,4'h3,32'h1002,32'h12345678, 0,1, 32'h0BADF00D,32'hAAAA5555, 0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,4'h3,32'h1002,32'h12345678, 0,0, 32'h0BADF00D,32'hCAFEF00D, 0,0));
    // dbus timeout: 4 BUSY cycles then error RESP
    tbl.push_back(mk(1,0,0,1,0,32'h300,0,0,0, 0,4'h3,32'h1002,32'h12345678, 0,1, 32'h0BADF00D,32'hCAFEF00D, 0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1,0,0,1,0,32'h300,0,0,0, 1,0,32'h300,0, 0,1, 32'h0BADF00D,32'hCAFEF00D, 0,0));
    tbl.push_back(mk(1,0,0,1,0,32'h300,0,0,0, 0,0,32'h300,0, 0,0, 32'h0BADF00D,32'hCAFEF00D, 0,1));
    // stray ack in IDLE is ignored
    tbl.push_back(mk(1,0,0,0,0,0,0,1,32'hFFFFFFFF, 0,0,32'h300,0, 0,0, 32'h0BADF00D,32'hCAFEF00D, 0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,32'h300,0, 0,0, 32'h0BADF00D,32'hCAFEF00D, 0,0));
    // reset mid-transfer, then late ack
    tbl.push_back(mk(1,1,32'h400,0,0,0,0,0,0, 0,0,32'h300,0, 1,0, 32'h0BADF00D,32'hCAFEF00D, 0,0));
    tbl.push_back(mk(0,1,32'h400,0,0,0,0,0,0, 1,0,32'h400,0, 1,0, 32'h0BADF00D,32'hCAFEF00D, 0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,32'h55555555, 0,0,0,0, 0,0, 0,0, 0,0));
    // ibus timeout
    tbl.push_back(mk(1,1,32'h500,0,0,0,0,0,0, 0,0,0,0, 1,0, 0,0, 0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1,1,32'h500,0,0,0,0,0,0, 1,0,32'h500,0, 1,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,32'h500,0,0,0,0,0,0, 0,0,32'h500,0, 0,0, 0,0, 1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,32'h500,0, 0,0, 0,0, 0,0));

    rst = 1'b0; i_en = 1'b0; i_addr = '0;
    d_en = 1'b0; d_we = '0; d_addr = '0; d_data_w = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    for (int s = 0; s < tbl.size(); s++) begin
      @(negedge clk);
      rst = tbl[s].rst; i_en = tbl[s].ien; i_addr = tbl[s].ia;
      d_en = tbl[s].den; d_we = tbl[s].dwe; d_addr = tbl[s].da;
      d_data_w = tbl[s].dw; mem_ack = tbl[s].ack; mem_rdata = tbl[s].rd;
      #1;
      chk(s, "mem_req", 32'(mem_req), 32'(tbl[s].e_req));
      chk(s, "mem_we", 32'(mem_we), 32'(tbl[s].e_we));
      chk(s, "mem_addr", mem_addr, tbl[s].e_addr);
      chk(s, "mem_wdata", mem_wdata, tbl[s].e_wd);
      chk(s, "i_stall", 32'(i_stall), 32'(tbl[s].e_is));
      chk(s, "d_stall", 32'(d_stall), 32'(tbl[s].e_ds));
      chk(s, "i_data_r", i_data_r, tbl[s].e_idr);
      chk(s, "d_data_r", d_data_r, tbl[s].e_ddr);
      chk(s, "i_err", 32'(i_err), 32'(tbl[s].e_ie));
      chk(s, "d_err", 32'(d_err), 32'(tbl[s].e_de));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one external memory port between the core's instruction bus (ibus) and data bus (dbus) sram-style masters.
- Sits between the datapath's ibus_sram/dbus_sram and the memory/bridge. It issues one transaction at a time, generates the per-master stall, and returns registered read data plus a bus-error pulse.
- A timeout watchdog turns a hung memory into a bus error instead of a permanent pipeline stall.

Parameters:
- TIMEOUT, 255, max cycles mem_req may stay high without mem_ack; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_en  in  1  ibus request; held with stable i_addr until i_stall is low
- i_addr  in  32  ibus byte address
- i_stall  out  1  high while an ibus request is outstanding
- i_data_r  out  32  ibus read data
- i_err  out  1  ibus error pulse (timeout)
- d_en  in  1  dbus request
- d_we  in  4  dbus byte write strobes; 0 means read
- d_addr  in  32  dbus byte address
- d_data_w  in  32  dbus write data
- d_stall  out  1  high while a dbus request is outstanding
- d_data_r  out  32  dbus read data
- d_err  out  1  dbus error pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  4  byte strobes; always 0 for ibus transfers
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  read data, valid only with mem_ack
- mem_ack  in  1  one-cycle transfer completion

Behaviour:
- State machine: IDLE, BUSY, RESP. Registers: owner (I/D), latched addr/we/wdata, watchdog counter, i_data_r, d_data_r.
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, i_data_r, d_data_r, i_err and d_err all go to 0.
  - Counter and owner go to 0.
  - Reset mid-transfer abandons the transfer; mem_req drops the next cycle.
- IDLE:
  - If d_en, latch the dbus request and go to BUSY with owner=D.
  - Otherwise, if i_en, latch the ibus request (we=0, wdata=0) and go to BUSY with owner=I.
  - Fixed priority: dbus wins a simultaneous request.
- BUSY:
  - mem_req=1 and mem_* are driven from the latched registers, stable for the whole state.
  - mem_ack may arrive in the first BUSY cycle.
  - On mem_ack, capture mem_rdata into the owner's data_r (writes also capture mem_rdata) and go to RESP.
  - Counter increments each BUSY cycle without ack.
  - If TIMEOUT!=0 and the counter equals TIMEOUT-1 with no ack: go to RESP and set owner's err=1. The owner's data_r is left unchanged.
  - mem_ack is ignored outside BUSY.
- RESP: mem_req=0, counter cleared; the owner's stall is low for exactly this cycle. Always go to IDLE next, so a master still holding en with its old address is never re-issued.
- Stall rules:
  - x_stall = x_en && !(state==RESP && owner==x).
  - When a master's en is low, its stall is low.
  - The non-owner stays stalled through BUSY and RESP.
- Error pulses: i_err/d_err are high only during the RESP cycle of a timed-out transfer, else 0.
- data_r holding: x_data_r holds its value until the next successful transfer for that master.
- Latency: the minimum is 3 cycles from en to the stall-low cycle (IDLE, BUSY+ack, RESP). Back-to-back requests from the same master issue every 3 cycles at best.
- Starvation: continuous d_en may starve ibus. This is accepted in fixed-priority mode.
- Request withdrawn: a master dropping en while its request is in BUSY is a protocol violation. The transfer completes anyway and the result is discarded (stall is 0 because en is 0).

Optional Feature:
- Macro SRAM_ARBITER_RR_EN.
- Defined: round-robin grant in IDLE when both masters request. Grant goes to the master not served last; a last_owner register resets to I, so dbus wins the first tie after reset. A lone requester is always granted.
- Undefined: fixed dbus priority as above, and no last_owner register.

Test Plan:
- ibus read: i_en=1, i_addr=0xBFC00000; mem_ack in first BUSY cycle with mem_rdata=0x3C080001 -> mem_req high 1 cycle, mem_we=0; i_stall high 2 cycles then low 1 cycle with i_data_r=0x3C080001; i_err=0.
- Simultaneous requests: i_en (0x100) and d_en write (d_we=4'b1111, d_addr=0x200, d_data_w=0xDEADBEEF), ack after 2 cycles each -> first mem transfer addr 0x200/we 0xF/wdata 0xDEADBEEF, then 0x100/we 0. i_stall stays high until its own RESP. With SRAM_ARBITER_RR_EN and both held continuously -> grants alternate D, I, D, I.
- Timeout: TIMEOUT=4, d_en read, no mem_ack -> mem_req high exactly 4 cycles, then RESP with d_err=1 for 1 cycle and d_stall low; d_data_r unchanged.
- No re-issue: i_en held high across RESP with the same address, ack immediate -> exactly one mem_req pulse per 3-cycle window. A new i_addr is sampled in the following IDLE.
- Reset mid-transfer: rst=0 during BUSY -> next cycle mem_req=0, state IDLE, data_r=0. A later mem_ack while IDLE has no effect.
- Byte write: d_we=4'b0011, d_addr=0x1002 -> mem_we=4'b0011, mem_addr=0x1002 passed through unchanged.
